// File: rtl/text_console_writer_pkg.sv
// Shared text-mode constants: screen geometry, control codes, blank cell,
// glyph geometry for the renderer, and the writer FSM state type.
package text_console_writer_pkg;

    localparam int TEXT_COLS        = 80;
    localparam int TEXT_ROWS        = 60;
    localparam int TEXT_ADDR_WIDTH  = 13;
    localparam int TEXT_CELL_WIDTH  = 16;
    localparam int GLYPH_WIDTH      = 8;
    localparam int GLYPH_HEIGHT     = 8;

    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    localparam logic [7:0]  DEFAULT_CLEAR_COLOUR = 8'h0F;
    localparam logic [15:0] BLANK_CELL           = {DEFAULT_CLEAR_COLOUR, CHAR_SPACE};

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_ROW,
        CLEAR_ALL
    } state_e;

    // row*80 + col built from shifts so no multiplier is needed.
    function automatic logic [12:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
        cell_addr = ({7'd0, row} << 6) + ({7'd0, row} << 4) + {6'd0, col};
    endfunction

endpackage

// File: rtl/text_console_writer.sv
// Character-stream to text-buffer writer: places printable codes at the cursor,
// handles BS/LF/FF/CR, and blanks rows or the whole screen with a write per cycle.
module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter int COLS                                  = TEXT_COLS,
    parameter int ROWS                                  = TEXT_ROWS,
    parameter int TEXT_DATA_WIDTH                       = 8,
    parameter int TEXT_COLOUR_WIDTH                     = 8,
    parameter logic [TEXT_COLOUR_WIDTH-1:0] CLEAR_COLOUR = DEFAULT_CLEAR_COLOUR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [TEXT_DATA_WIDTH-1:0]   in_char,
    input  logic [TEXT_COLOUR_WIDTH-1:0] in_colour,
    output logic                         wr_en,
    output logic [12:0]                  wr_addr,
    output logic [15:0]                  wr_data,
    output logic [6:0]                   cursor_col,
    output logic [5:0]                   cursor_row,
    output logic                         busy
);

    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
    localparam logic [12:0] LAST_CELL = 13'(ROWS * COLS - 1);
    localparam logic [15:0] BLANK     = 16'({CLEAR_COLOUR, CHAR_SPACE});

    state_e      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [12:0] clr_addr_q, clr_addr_d;
    logic [12:0] clr_last_q, clr_last_d;
    logic        wr_en_q, wr_en_d;
    logic [12:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [5:0]  next_row;

    assign next_row = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        clr_addr_d = clr_addr_q;
        clr_last_d = clr_last_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (8'(in_char))
                        CHAR_CR: col_d = 7'd0;
                        CHAR_LF: begin
                            col_d      = 7'd0;
                            row_d      = next_row;
                            state_d    = CLEAR_ROW;
                            clr_addr_d = cell_addr(next_row, 7'd0);
                            clr_last_d = cell_addr(next_row, LAST_COL);
                        end
                        CHAR_BS: begin
                            if (col_q != 7'd0) begin
                                col_d     = col_q - 7'd1;
                                wr_en_d   = 1'b1;
                                wr_addr_d = cell_addr(row_q, col_q - 7'd1);
                                wr_data_d = BLANK;
                            end
                        end
                        CHAR_FF: begin
                            state_d    = CLEAR_ALL;
                            clr_addr_d = 13'd0;
                            clr_last_d = LAST_CELL;
                        end
                        default: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = cell_addr(row_q, col_q);
                            wr_data_d = 16'({in_colour, in_char});
                            if (col_q == LAST_COL) begin
                                col_d      = 7'd0;
                                row_d      = next_row;
                                state_d    = CLEAR_ROW;
                                clr_addr_d = cell_addr(next_row, 7'd0);
                                clr_last_d = cell_addr(next_row, LAST_COL);
                            end else begin
                                col_d = col_q + 7'd1;
                            end
                        end
                    endcase
                end
            end
            CLEAR_ROW, CLEAR_ALL: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = clr_addr_q;
                wr_data_d  = BLANK;
                clr_addr_d = clr_addr_q + 13'd1;
                if (clr_addr_q == clr_last_q) begin
                    state_d = IDLE;
                    if (state_q == CLEAR_ALL) begin
                        col_d = 7'd0;
                        row_d = 6'd0;
                    end
                end
            end
            default: state_d = CLEAR_ALL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ALL;
            col_q      <= 7'd0;
            row_q      <= 6'd0;
            clr_addr_q <= 13'd0;
            clr_last_q <= LAST_CELL;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 13'd0;
            wr_data_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            clr_addr_q <= clr_addr_d;
            clr_last_q <= clr_last_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 The block SHALL have these parameters, each given as name, default, meaning:
- COLS, 80, text columns per row.
- ROWS, 60, text rows.
- TEXT_DATA_WIDTH, 8, character code width.
- TEXT_COLOUR_WIDTH, 8, colour width: low nibble = foreground, high nibble = background.
- CLEAR_COLOUR, 8'h0F, colour written with blanking spaces.
REQ-002 The block SHALL have these ports, each given as name, direction, width, meaning:
- clk, in, 1, the single clock.
- rst, in, 1, reset; synchronous and active-high.
- in_valid, in, 1, character offered.
- in_ready, out, 1, block can accept a character.
- in_char, in, TEXT_DATA_WIDTH, character code.
- in_colour, in, TEXT_COLOUR_WIDTH, colour for this character.
- wr_en, out, 1, text-buffer write strobe.
- wr_addr, out, 13, cell address = row*COLS+col.
- wr_data, out, 16, {colour, char}.
- cursor_col, out, 7, current column.
- cursor_row, out, 6, current row.
- busy, out, 1, a clear sequence is in progress.

Function
REQ-003 A transfer SHALL occur on a rising clk edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 only in state IDLE, decoded from the state register.
REQ-004 The FSM SHALL have three states: IDLE, CLEAR_ROW, CLEAR_ALL.
REQ-005 In IDLE, an accepted code other than 0x08, 0x0A, 0x0C or 0x0D SHALL be written with wr_en=1, wr_addr=cursor cell and wr_data={in_colour,in_char} on the cycle after acceptance, and the cursor SHALL advance one column.
REQ-006 If the written cell was at col COLS-1, the cursor SHALL move to col 0, row+1 (ROWS-1 wraps to 0), and the FSM SHALL enter CLEAR_ROW for the new row.
REQ-007 Code 0x0D (CR) SHALL set col=0 with no write.
REQ-008 Code 0x0A (LF) SHALL set col=0, row+1 with wrap, and enter CLEAR_ROW; no write of the LF code itself.
REQ-009 Code 0x08 (BS) at col>0 SHALL decrement col and write {CLEAR_COLOUR,8'h20} at the new position; at col=0 it SHALL do nothing.
REQ-010 Code 0x0C (FF) SHALL enter CLEAR_ALL.
REQ-011 CLEAR_ROW SHALL write {CLEAR_COLOUR,8'h20} to the COLS cells of cursor_row, one per cycle, in ascending address order, then return to IDLE; the cursor SHALL be unchanged.
REQ-012 CLEAR_ALL SHALL write the blank cell to addresses 0..ROWS*COLS-1 (0..4799), one per cycle, then set the cursor to (0,0) and return to IDLE.
REQ-013 busy SHALL equal (state != IDLE); wr_en SHALL be 1 on every clear-sequence cycle.
REQ-014 Back-to-back printable characters SHALL be accepted every cycle; in_ready SHALL fall the cycle after an accept that triggers a clear.
REQ-015 in_valid asserted while in_ready=0 SHALL be held off with no loss; in_char and in_colour are sampled only on transfer.
REQ-016 wr_addr SHALL be computed as (row<<6)+(row<<4)+col in 13 bits; the wr_* outputs SHALL be registered.

Reset
REQ-017 On rst=1 at a clk edge, the block SHALL set cursor=(0,0), wr_en=0, wr_addr=0 and wr_data=0.
REQ-018 On reset the FSM SHALL enter CLEAR_ALL, so in_ready=0 and busy=1 after reset until blanking completes.
REQ-019 Reset asserted mid-sequence SHALL abort that sequence, discard any pending write, and restart CLEAR_ALL from address 0.

Structure
REQ-020 COLS, ROWS, the control codes (BS/LF/FF/CR) and the blank-cell value SHALL live in a shared package with the text-renderer constants.
REQ-021 The block SHALL be a single module with no sub-modules; an optional cell-address helper function is permitted.

Verification
REQ-022 Reset, then monitor -> exactly 4800 writes of 16'h0F20 to addresses 0..4799, then in_ready=1 and cursor (0,0).
REQ-023 Send 'A','B' back-to-back with colour 8'h1E -> writes 16'h1E41 @0 and 16'h1E42 @1, then cursor (2,0).
REQ-024 Send 80 printable characters from (0,0) -> write at address 79, then 80 blank writes at 80..159, then cursor (0,1).
REQ-025 At (5,59) send LF -> cursor (0,0), blank writes at 0..79; then BS at col 0 -> no write.
REQ-026 At (3,2) send BS -> write 16'h0F20 @162 and cursor (2,2); then CR -> cursor (0,2) with no write.
REQ-027 Assert rst mid-CLEAR_ROW -> the next write goes to address 0 and the full 4800-cell clear completes.
